eq_coeff_ctrl: RTL and testbench

- OPB slave controller that sequences loading of per-channel EQ gain coefficients into the double-buffered coefficient RAM of the F-engine equalizer/quantizer stage.
- Software streams coefficients through one data register; an auto-incrementing channel pointer writes them into the inactive bank.
- A software commit arms a bank swap, which executes on the next datapath sync pulse so spectra never see mixed coefficient sets.

---
 rtl/eq_coeff_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_eq_coeff_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_coeff_ctrl.sv
// OPB slave that streams per-channel EQ gain coefficients into the inactive bank
// of a double-buffered coefficient RAM and swaps banks on the next datapath sync.
module eq_coeff_ctrl #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR = 32'h01000A00,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR = 32'h01000AFF,
  parameter int N_CHAN_BITS = 10,
  parameter int COEF_WIDTH = 16
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic                        sync_in,
  output logic                        coef_we,
  output logic [N_CHAN_BITS-1:0]      coef_addr,
  output logic [COEF_WIDTH-1:0]       coef_data,
  output logic                        coef_wbank,
  output logic                        active_bank,
  output logic                        bank_swap
);

  localparam int DW = C_OPB_DWIDTH;
  localparam int AW = C_OPB_AWIDTH;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_DATA   = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  // Little-endian views of the OPB buses; the [0:N] to [N-1:0] copy keeps the numeric value.
  logic [AW-1:0] addr_v;
  logic [DW-1:0] wdata_v;
  logic [AW-1:0] addr_off;
  logic [7:0]    offset;
  logic          in_range;

  assign addr_v   = OPB_ABus;
  assign wdata_v  = OPB_DBus;
  assign addr_off = addr_v - C_BASEADDR;
  assign offset   = addr_off[7:0];
  assign in_range = (addr_v >= C_BASEADDR) && (addr_v <= C_HIGHADDR);

  // ---------------------------------------------------------------------------
  // Slave handshake FSM
  // ---------------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   start;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (OPB_select && in_range) begin
          state_next = S_ACK;
          start      = 1'b1;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file and coefficient sequencing
  // ---------------------------------------------------------------------------
  logic                   wr_ctrl, wr_data, swap;
  logic [N_CHAN_BITS-1:0] ptr_reg, ptr_next;
  logic                   pending_reg, pending_next;
  logic                   overrun_reg, overrun_next;
  logic                   active_bank_reg, active_bank_next;
  logic                   bank_swap_reg, bank_swap_next;
  logic                   coef_we_reg, coef_we_next;
  logic [N_CHAN_BITS-1:0] coef_addr_reg, coef_addr_next;
  logic [COEF_WIDTH-1:0]  coef_data_reg, coef_data_next;
  logic [DW-1:0]          dbus_reg, dbus_next;
  logic [DW-1:0]          status_word, rd_value;

  assign wr_ctrl = start && !OPB_RNW && (offset == OFF_CTRL);
  assign wr_data = start && !OPB_RNW && (offset == OFF_DATA);
  // Only a commit from an earlier cycle may arm the swap.
  assign swap    = sync_in && pending_reg;

  always_comb begin
    ptr_next         = ptr_reg;
    pending_next     = pending_reg;
    overrun_next     = overrun_reg;
    active_bank_next = active_bank_reg;
    bank_swap_next   = 1'b0;
    coef_we_next     = 1'b0;
    coef_addr_next   = coef_addr_reg;
    coef_data_next   = coef_data_reg;

    if (wr_ctrl) begin
      if (wdata_v[DW-3]) begin
        overrun_next = 1'b0;
      end
      if (wdata_v[DW-1]) begin
        ptr_next = '0;
      end
    end

    // Writing into a bank that is about to go live would corrupt it, so refuse and flag.
    if (wr_data) begin
      if (pending_reg) begin
        overrun_next = 1'b1;
      end else begin
        coef_we_next   = 1'b1;
        coef_addr_next = ptr_reg;
        coef_data_next = wdata_v[COEF_WIDTH-1:0];
        ptr_next       = ptr_reg + 1'b1;
      end
    end

    if (swap) begin
      active_bank_next = ~active_bank_reg;
      bank_swap_next   = 1'b1;
      pending_next     = 1'b0;
      ptr_next         = '0;
    end

    // A fresh commit re-arms even if a swap fires in the same cycle.
    if (wr_ctrl && wdata_v[DW-2]) begin
      pending_next = 1'b1;
    end
  end

  always_comb begin
    status_word          = '0;
    status_word[DW-1:DW-16] = 16'(ptr_reg);
    status_word[2:0]     = {overrun_reg, active_bank_reg, pending_reg};
  end

  always_comb begin
    rd_value = '0;
    case (offset)
      OFF_CTRL, OFF_STATUS: rd_value = status_word;
      OFF_DATA:             rd_value[COEF_WIDTH-1:0] = coef_data_reg;
      default:              rd_value = '0;
    endcase
  end

  // Read data is captured at the start edge so the bus is only non-zero during the ack cycle.
  assign dbus_next = (start && OPB_RNW) ? rd_value : '0;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ptr_reg         <= '0;
      pending_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      active_bank_reg <= 1'b0;
      bank_swap_reg   <= 1'b0;
      coef_we_reg     <= 1'b0;
      coef_addr_reg   <= '0;
      coef_data_reg   <= '0;
      dbus_reg        <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      pending_reg     <= pending_next;
      overrun_reg     <= overrun_next;
      active_bank_reg <= active_bank_next;
      bank_swap_reg   <= bank_swap_next;
      coef_we_reg     <= coef_we_next;
      coef_addr_reg   <= coef_addr_next;
      coef_data_reg   <= coef_data_next;
      dbus_reg        <= dbus_next;
    end
  end

  assign Sl_DBus     = dbus_reg;
  assign Sl_xferAck  = (state_reg == S_ACK);
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign coef_we     = coef_we_reg;
  assign coef_addr   = coef_addr_reg;
  assign coef_data   = coef_data_reg;
  assign active_bank = active_bank_reg;
  assign coef_wbank  = ~active_bank_reg;
  assign bank_swap   = bank_swap_reg;

  // Byte enables, sequential-address hint and the middle data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{OPB_BE, OPB_seqAddr, addr_off[AW-1:8], wdata_v[DW-4:COEF_WIDTH]};

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
// Directed bench for eq_coeff_ctrl: table-driven register accesses plus
// hand-written sequences for pointer wrap, bank swap, overrun and reset.
module tb_eq_coeff_ctrl;

  localparam logic [31:0] BASE = 32'h01000A00;

  logic        OPB_Clk;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        sync_in;
  logic        coef_we;
  logic [9:0]  coef_addr;
  logic [15:0] coef_data;
  logic        coef_wbank;
  logic        active_bank;
  logic        bank_swap;

  int total = 0;
  int bad   = 0;

  eq_coeff_ctrl dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst     (OPB_Rst),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_xferAck  (Sl_xferAck),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .sync_in     (sync_in),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_wbank  (coef_wbank),
    .active_bank (active_bank),
    .bank_swap   (bank_swap)
  );

  initial begin
    OPB_Clk = 1'b0;
    forever #5 OPB_Clk = ~OPB_Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rnw;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_we;
    logic [9:0]  exp_ca;
    logic [15:0] exp_cd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One OPB transfer; returns what was seen in the ack cycle and leaves the FSM idle.
  task automatic xfer(input bit rnw, input logic [7:0] off, input logic [31:0] wd,
                      output logic [31:0] rd, output bit we, output logic [9:0] ca,
                      output logic [15:0] cd, output bit wb, output int lat);
    int c;
    OPB_ABus   = BASE + {24'h0, off};
    OPB_DBus   = rnw ? 32'h0 : wd;
    OPB_RNW    = rnw;
    OPB_select = 1'b1;
    lat = 0; c = 0; rd = '0; we = 0; ca = '0; cd = '0; wb = 0;
    while (lat == 0 && c < 8) begin
      @(posedge OPB_Clk); #1;
      sync_in = 1'b0;
      c++;
      if (Sl_xferAck) begin
        lat = c; rd = Sl_DBus; we = coef_we; ca = coef_addr; cd = coef_data; wb = coef_wbank;
      end
    end
    OPB_select = 1'b0;
    OPB_RNW    = 1'b0;
    @(posedge OPB_Clk); #1;
    $display("xfer %s off=%h wd=%h rd=%h we=%0d addr=%0d data=%h lat=%0d",
             rnw ? "R" : "W", off, wd, rd, we, ca, cd, lat);
  endtask

  task automatic pulse_sync(output bit sw, output bit ab);
    sync_in = 1'b1;
    @(posedge OPB_Clk); #1;
    sync_in = 1'b0;
    sw = bank_swap;
    ab = active_bank;
    $display("sync bank_swap=%0d active_bank=%0d", sw, ab);
  endtask

  task automatic rd_status(input string nm, input logic [31:0] exp);
    logic [31:0] rd; bit we; logic [9:0] ca; logic [15:0] cd; bit wb; int lat;
    xfer(1'b1, 8'h08, 32'h0, rd, we, ca, cd, wb, lat);
    chk({nm, "_lat"}, lat, 1);
    chk(nm, rd, exp);
  endtask

  task automatic wr_reg(input string nm, input logic [7:0] off, input logic [31:0] wd,
                        input bit exp_we);
    logic [31:0] rd; bit we; logic [9:0] ca; logic [15:0] cd; bit wb; int lat;
    xfer(1'b0, off, wd, rd, we, ca, cd, wb, lat);
    chk({nm, "_lat"}, lat, 1);
    chk({nm, "_we"}, we, exp_we);
  endtask

  initial begin
    logic [31:0] rd; bit we; logic [9:0] ca; logic [15:0] cd; bit wb; int lat;
    bit sw, ab;
    int acks;
    logic [3:0] ack_pat;

    vecs[0]  = '{1'b1, 8'h08, 32'h0,        32'h00000000, 1'b0, 10'd0, 16'h0000};
    vecs[1]  = '{1'b0, 8'h04, 32'h00001234, 32'h00000000, 1'b1, 10'd0, 16'h1234};
    vecs[2]  = '{1'b0, 8'h04, 32'h00005678, 32'h00000000, 1'b1, 10'd1, 16'h5678};
    vecs[3]  = '{1'b1, 8'h08, 32'h0,        32'h00020000, 1'b0, 10'd0, 16'h0000};
    vecs[4]  = '{1'b1, 8'h00, 32'h0,        32'h00020000, 1'b0, 10'd0, 16'h0000};
    vecs[5]  = '{1'b1, 8'h04, 32'h0,        32'h00005678, 1'b0, 10'd0, 16'h0000};
    vecs[6]  = '{1'b1, 8'h0C, 32'h0,        32'h00000000, 1'b0, 10'd0, 16'h0000};
    vecs[7]  = '{1'b0, 8'h0C, 32'hDEADBEEF, 32'h00000000, 1'b0, 10'd0, 16'h0000};
    vecs[8]  = '{1'b1, 8'h08, 32'h0,        32'h00020000, 1'b0, 10'd0, 16'h0000};
    vecs[9]  = '{1'b0, 8'h00, 32'h80000000, 32'h00000000, 1'b0, 10'd0, 16'h0000};
    vecs[10] = '{1'b1, 8'h08, 32'h0,        32'h00000000, 1'b0, 10'd0, 16'h0000};
    vecs[11] = '{1'b0, 8'h04, 32'hABCD5555, 32'h00000000, 1'b1, 10'd0, 16'h5555};
    vecs[12] = '{1'b1, 8'h04, 32'h0,        32'h00005555, 1'b0, 10'd0, 16'h0000};
    vecs[13] = '{1'b1, 8'h08, 32'h0,        32'h00010000, 1'b0, 10'd0, 16'h0000};

    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = 4'hF; OPB_DBus = '0; OPB_RNW = 1'b0;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; sync_in = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("rst_ack", Sl_xferAck, 0);
    chk("rst_dbus", Sl_DBus, 0);
    chk("rst_we", coef_we, 0);
    chk("rst_wbank", coef_wbank, 1);
    chk("rst_active", active_bank, 0);
    chk("rst_swap", bank_swap, 0);
    OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;

    // Register map basics
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].rnw, vecs[i].off, vecs[i].wd, rd, we, ca, cd, wb, lat);
      chk($sformatf("v%0d_lat", i), lat, 1);
      chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_we", i), we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_addr", i), ca, vecs[i].exp_ca);
        chk($sformatf("v%0d_data", i), cd, vecs[i].exp_cd);
        chk($sformatf("v%0d_wbank", i), wb, 1);
      end
    end

    // Out-of-window select must never be acked
    foreach (ack_pat[k]) ack_pat[k] = 1'b0;
    acks = 0;
    OPB_ABus = BASE + 32'h100; OPB_RNW = 1'b1; OPB_select = 1'b1;
    repeat (3) begin @(posedge OPB_Clk); #1; if (Sl_xferAck) acks++; end
    OPB_ABus = BASE - 32'h4;
    repeat (3) begin @(posedge OPB_Clk); #1; if (Sl_xferAck) acks++; end
    OPB_select = 1'b0; OPB_RNW = 1'b0;
    chk("outside_window_acks", acks, 0);

    // Select held: ack every second cycle, never twice in a row
    OPB_ABus = BASE + 32'h8; OPB_RNW = 1'b1; OPB_select = 1'b1;
    for (int k = 3; k >= 0; k--) begin @(posedge OPB_Clk); #1; ack_pat[k] = Sl_xferAck; end
    OPB_select = 1'b0; OPB_RNW = 1'b0;
    @(posedge OPB_Clk); #1;
    $display("held select ack pattern=%b", ack_pat);
    chk("held_select_pattern", ack_pat, 4'b1010);

    // Pointer wrap across all 1024 channels
    wr_reg("ptr_reset", 8'h00, 32'h80000000, 1'b0);
    for (int i = 0; i < 1025; i++) begin
      xfer(1'b0, 8'h04, 32'h00010000 | (i + 32'h100), rd, we, ca, cd, wb, lat);
      chk($sformatf("wrap%0d_we", i), we, 1);
      chk($sformatf("wrap%0d_addr", i), ca, (i == 1024) ? 0 : i);
      chk($sformatf("wrap%0d_data", i), cd, (i + 32'h100) & 32'hFFFF);
    end
    rd_status("wrap_status", 32'h00010000);

    // Commit, then sync five cycles later
    wr_reg("commit1", 8'h00, 32'h40000000, 1'b0);
    rd_status("pending_status", 32'h00010001);
    repeat (5) @(posedge OPB_Clk);
    #1;
    chk("pre_sync_active", active_bank, 0);
    pulse_sync(sw, ab);
    chk("sync1_swap", sw, 1);
    chk("sync1_active", ab, 1);
    chk("sync1_wbank", coef_wbank, 0);
    @(posedge OPB_Clk); #1;
    chk("sync1_swap_one_cycle", bank_swap, 0);
    rd_status("post_swap_status", 32'h00000002);

    // Commit coinciding with sync: swap must wait for the next sync
    sync_in = 1'b1;
    xfer(1'b0, 8'h00, 32'h40000000, rd, we, ca, cd, wb, lat);
    chk("same_cycle_lat", lat, 1);
    chk("same_cycle_active", active_bank, 1);
    rd_status("same_cycle_status", 32'h00000003);
    pulse_sync(sw, ab);
    chk("sync2_swap", sw, 1);
    chk("sync2_active", ab, 0);
    rd_status("sync2_status", 32'h00000000);

    // Overrun while pending; multi-bit CTRL clears overrun and ptr before committing
    xfer(1'b0, 8'h04, 32'h00001111, rd, we, ca, cd, wb, lat);
    chk("ov_w0_addr", ca, 0);
    chk("ov_w0_wbank", wb, 1);
    xfer(1'b0, 8'h04, 32'h00002222, rd, we, ca, cd, wb, lat);
    chk("ov_w1_addr", ca, 1);
    wr_reg("commit3", 8'h00, 32'h40000000, 1'b0);
    wr_reg("overrun_write", 8'h04, 32'h00003333, 1'b0);
    rd_status("overrun_status", 32'h00020005);
    xfer(1'b1, 8'h04, 32'h0, rd, we, ca, cd, wb, lat);
    chk("overrun_data_kept", rd, 32'h00002222);
    wr_reg("clear_overrun", 8'h00, 32'h20000000, 1'b0);
    rd_status("cleared_status", 32'h00020001);
    wr_reg("overrun_write2", 8'h04, 32'h00004444, 1'b0);
    rd_status("overrun2_status", 32'h00020005);
    wr_reg("ctrl_all", 8'h00, 32'hE0000000, 1'b0);
    rd_status("ctrl_all_status", 32'h00000001);
    pulse_sync(sw, ab);
    chk("sync3_swap", sw, 1);
    chk("sync3_active", ab, 1);
    // sync without a pending commit does nothing
    pulse_sync(sw, ab);
    chk("idle_sync_swap", sw, 0);
    chk("idle_sync_active", ab, 1);

    // Reset asserted during the ack of a DATA write
    xfer(1'b0, 8'h04, 32'h00000001, rd, we, ca, cd, wb, lat);
    OPB_ABus = BASE + 32'h4; OPB_DBus = 32'h00007777; OPB_RNW = 1'b0; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    chk("mid_ack", Sl_xferAck, 1);
    chk("mid_we", coef_we, 1);
    chk("mid_addr", coef_addr, 1);
    OPB_Rst = 1'b1; OPB_select = 1'b0;
    @(posedge OPB_Clk); #1;
    $display("reset mid-ack ack=%0d we=%0d addr=%0d data=%h active=%0d", Sl_xferAck, coef_we,
             coef_addr, coef_data, active_bank);
    chk("mrst_ack", Sl_xferAck, 0);
    chk("mrst_dbus", Sl_DBus, 0);
    chk("mrst_we", coef_we, 0);
    chk("mrst_addr", coef_addr, 0);
    chk("mrst_data", coef_data, 0);
    chk("mrst_active", active_bank, 0);
    chk("mrst_wbank", coef_wbank, 1);
    chk("mrst_swap", bank_swap, 0);
    OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;
    rd_status("post_reset_status", 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
